counter_bist_checker: RTL

//  On-chip stimulus/response engine for the Counter accumulator: drives its clear_n and addBy

---
 rtl/counter_bist_checker.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/counter_bist_checker.sv
// Synthesizable self-test engine for the Counter accumulator: drives its clear/increment inputs,
// checks the running count every clock and reports pass, mismatch count and first failing step.
module counter_bist_checker #(
   parameter int WIDTH = 4,
   parameter int TICKS = 5,
   parameter int NUM_STEPS = 5,
   parameter logic [WIDTH*NUM_STEPS-1:0] STEP_VALS = 20'hF8710,
   parameter int ERR_WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 clear_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     count,
   output logic                 ctr_clear_n,
   output logic [WIDTH-1:0]     addBy,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_WIDTH-1:0] err_count,
   output logic [2:0]           fail_step
);

   localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [TICK_W-1:0]    TICK_LAST  = TICK_W'(TICKS - 1);
   localparam logic [2:0]           STEP_LAST  = 3'(NUM_STEPS - 1);
   localparam logic [2:0]           FAIL_FINAL = 3'(NUM_STEPS);
   localparam logic [2:0]           FAIL_NONE  = 3'd7;
   localparam logic [ERR_WIDTH-1:0] ERR_ZERO   = {ERR_WIDTH{1'b0}};
   localparam logic [ERR_WIDTH-1:0] ERR_MAX    = {ERR_WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]     VAL_ZERO   = {WIDTH{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_TICK   = 3'd3,
      ST_FCLEAR = 3'd4,
      ST_FCHECK = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   state_t               state_r;
   state_t               state_nx_s;
   logic [2:0]           step_r;
   logic [2:0]           step_nx_s;
   logic [TICK_W-1:0]    tick_r;
   logic [TICK_W-1:0]    tick_nx_s;
   logic [WIDTH-1:0]     expected_r;
   logic [WIDTH-1:0]     expected_nx_s;
   logic [ERR_WIDTH-1:0] err_nx_s;
   logic [2:0]           fail_nx_s;
   logic                 cmp_en_s;
   logic                 mismatch_s;
   logic [WIDTH-1:0]     cur_val_s;
   logic                 ccn_nx_s;
   logic [WIDTH-1:0]     addby_nx_s;
   logic                 busy_nx_s;
   logic                 done_nx_s;
   logic                 pass_nx_s;

   function automatic logic [WIDTH-1:0] step_val(input logic [2:0] s);
      logic [WIDTH-1:0] v;
      v = VAL_ZERO;
      for (int i = 0; i < NUM_STEPS; i++) begin
         if (s == 3'(i)) begin
            v = STEP_VALS[i*WIDTH +: WIDTH];
         end else begin
            v = v;
         end
      end
      return v;
   endfunction

   function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
      if (v == ERR_MAX) begin
         return v;
      end else begin
         return v + ERR_WIDTH'(1);
      end
   endfunction

   // Increment applied during the current step.
   always_comb begin
      cur_val_s = step_val(step_r);
   end

   // Equality written so an unknown count lands on the mismatch branch in simulation.
   always_comb begin
      mismatch_s = 1'b1;
      if (count == expected_r) begin
         mismatch_s = 1'b0;
      end else begin
         mismatch_s = 1'b1;
      end
   end

   // Sequencer: next state, step/tick bookkeeping, expected value and error statistics.
   always_comb begin
      state_nx_s    = state_r;
      step_nx_s     = step_r;
      tick_nx_s     = tick_r;
      expected_nx_s = expected_r;
      err_nx_s      = err_count;
      fail_nx_s     = fail_step;
      cmp_en_s      = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nx_s = ST_CLEAR;
               err_nx_s   = ERR_ZERO;
               fail_nx_s  = FAIL_NONE;
               step_nx_s  = 3'd0;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_CLEAR: begin
            state_nx_s    = ST_SETUP;
            expected_nx_s = VAL_ZERO;
         end
         ST_SETUP: begin
            state_nx_s    = ST_TICK;
            expected_nx_s = cur_val_s;
            tick_nx_s     = {TICK_W{1'b0}};
         end
         ST_TICK: begin
            cmp_en_s      = 1'b1;
            expected_nx_s = expected_r + cur_val_s;
            tick_nx_s     = tick_r + TICK_W'(1);
            if (tick_r == TICK_LAST) begin
               if (step_r == STEP_LAST) begin
                  // FCHECK compares against expected_r, so park it at zero.
                  state_nx_s    = ST_FCLEAR;
                  expected_nx_s = VAL_ZERO;
               end else begin
                  state_nx_s = ST_CLEAR;
                  step_nx_s  = step_r + 3'd1;
               end
            end else begin
               state_nx_s = ST_TICK;
            end
         end
         ST_FCLEAR: begin
            state_nx_s = ST_FCHECK;
         end
         ST_FCHECK: begin
            cmp_en_s   = 1'b1;
            state_nx_s = ST_DONE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase

      if (cmp_en_s && mismatch_s) begin
         err_nx_s = sat_inc(err_count);
         if (err_count == ERR_ZERO) begin
            fail_nx_s = (state_r == ST_FCHECK) ? FAIL_FINAL : step_r;
         end else begin
            fail_nx_s = fail_step;
         end
      end else begin
         err_nx_s = err_nx_s;
      end
   end

   // Output values for the state being entered, so every output is a plain register.
   always_comb begin
      ccn_nx_s   = 1'b1;
      addby_nx_s = VAL_ZERO;
      case (state_nx_s)
         ST_CLEAR, ST_FCLEAR: begin
            ccn_nx_s   = 1'b0;
            addby_nx_s = VAL_ZERO;
         end
         ST_SETUP, ST_TICK: begin
            ccn_nx_s   = 1'b1;
            addby_nx_s = step_val(step_nx_s);
         end
         default: begin
            ccn_nx_s   = 1'b1;
            addby_nx_s = VAL_ZERO;
         end
      endcase
      busy_nx_s = (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
      done_nx_s = (state_nx_s == ST_DONE);
      pass_nx_s = (state_nx_s == ST_DONE) && (err_nx_s == ERR_ZERO);
   end

   // State, bookkeeping and output registers; reset aborts any run in progress.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_r     <= ST_IDLE;
         step_r      <= 3'd0;
         tick_r      <= {TICK_W{1'b0}};
         expected_r  <= VAL_ZERO;
         ctr_clear_n <= 1'b0;
         addBy       <= VAL_ZERO;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_count   <= ERR_ZERO;
         fail_step   <= FAIL_NONE;
      end else begin
         state_r     <= state_nx_s;
         step_r      <= step_nx_s;
         tick_r      <= tick_nx_s;
         expected_r  <= expected_nx_s;
         ctr_clear_n <= ccn_nx_s;
         addBy       <= addby_nx_s;
         busy        <= busy_nx_s;
         done        <= done_nx_s;
         pass        <= pass_nx_s;
         err_count   <= err_nx_s;
         fail_step   <= fail_nx_s;
      end
   end

endmodule
